load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access stage that sits directly downstream of the single-cycle datapath. It takes the datapath's ALU address, store data and load/store strobes and runs a request/grant/response transaction on the data bus. It stalls the core while the transaction is in flight, then returns sign- or zero-extended load data as `read_data`. It also handles byte/halfword lanes, misalignment checks and a bus watchdog.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles spent in REQ+WAIT before the access is aborted; legal range 2..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `srst_n` in 1: reset, asynchronous, active-low.
- `mem_r` in 1: load strobe from control.
- `mem_w` in 1: store strobe from control.
- `funct3` in 3: `instr[14:12]`, selects access size/sign.
- `addr` in 32: byte address (datapath `ALUresult`).
- `wdata` in 32: store data (datapath `write_data`).
- `read_data` out 32: extended load result, registered.
- `stall` out 1: freeze PC/register-file write while high.
- `access_err` out 1: misaligned or illegal access, one-cycle pulse.
- `bus_err` out 1: watchdog abort, one-cycle pulse.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: read data valid; earliest one cycle after `bus_gnt`.
- `bus_rdata` in 32: read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, no strobe: stay in IDLE.
- IDLE, legal access: latch `bus_*`, `funct3`, `addr[1:0]`, then go to REQ.
- IDLE, illegal access: pulse `access_err`, `stall`=0, no bus activity, stay in IDLE.
- Illegal access means any of:
  - `mem_r` and `mem_w` both high.
  - Load `funct3` not in {000,001,010,100,101}.
  - Store `funct3` not in {000,001,010}.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
- REQ: `bus_req`=1; all `bus_*` outputs held constant until `bus_gnt`.
  - Store + `bus_gnt`: go to DONE.
  - Load + `bus_gnt`: go to WAIT.
- WAIT: on `bus_rvalid`, capture the extended `bus_rdata` into `read_data` and go to DONE.
- DONE: `stall`=0 for one cycle so the core advances; then go to IDLE.
- `stall` = (`mem_r`|`mem_w`) & legal & (state≠DONE). It is combinational.
- Byte enables:
  - SB/LB/LBU: `1<<addr[1:0]`.
  - SH/LH/LHU: `0011` if `addr[1]`=0, else `1100`.
  - SW/LW: `1111`.
- Store data:
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: `wdata`.
- Load extraction from `bus_rdata`:
  - Byte lane selected by `addr[1:0]`; halfword lane by `addr[1]`.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- `read_data` holds its value until the next load reaches DONE. Stores and errors do not change it, except on watchdog abort (see below).
- Watchdog:
  - An 8-bit counter clears on IDLE→REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT-1` without completion, drop `bus_req`, go to DONE, and pulse `bus_err` in the DONE cycle.
  - On a load abort, `read_data` is set to 0.
- `bus_gnt` and `bus_rvalid` are ignored outside REQ and WAIT respectively.

## Timing
- Reset values: state IDLE; `read_data`=0; `bus_req`=0; `bus_we`=0; `bus_addr`=0; `bus_be`=0; `bus_wdata`=0; `access_err`=0; `bus_err`=0; counter=0.
- `stall`=0 while `srst_n` is low.
- Reset mid-transaction returns to IDLE immediately (asynchronous). `bus_req` drops without waiting for the clock, and in-flight data is discarded.
- Store, zero-wait grant: cycle 0 IDLE (stall=1), cycle 1 REQ + gnt (stall=1), cycle 2 DONE (stall=0). The core advances at the end of cycle 2.
- Load, gnt in cycle 1 and rvalid in cycle 2: `read_data` is valid in cycle 3 (DONE, stall=0). Minimum load latency is 4 cycles.
- Each wait cycle on `bus_gnt` or `bus_rvalid` adds one cycle.
- A back-to-back access is first seen in the IDLE cycle after DONE.
- `access_err` and `bus_err` never assert in the same cycle.

## Test plan
- LW: addr 0x100, gnt in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF -> `bus_be`=1111, `read_data`=0xDEADBEEF in cycle 3, `stall` high in cycles 0–2.
- LB/LBU: addr 0x103, rdata 0x80112233 -> LB gives `read_data`=0xFFFFFF80; LBU gives 0x00000080; `bus_addr`=0x100.
- SH: addr 0x202, wdata 0x0000ABCD -> `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_we`=1, DONE in cycle 2.
- Misaligned LW at 0x101 -> `access_err` pulse in cycle 0, `bus_req` never asserts, `stall`=0, `read_data` unchanged.
- Watchdog: `TIMEOUT`=4, `bus_gnt` never asserts -> `bus_req` drops after 4 REQ cycles, `bus_err` pulse in DONE, load `read_data`=0.
- Reset in WAIT: deassert `srst_n` mid-cycle -> `bus_req`/`stall`/`read_data` go to 0 immediately; a later rvalid is ignored; after release the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory access stage: runs one request/grant/response bus transaction per
// load/store, stalls the core while busy and returns extended load data.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        access_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  wd_cnt;
  logic        strobe, f3_ok, aligned, legal, start, abort, ld_done;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Access decode on the live strobes from the datapath
  always_comb begin
    strobe = mem_r | mem_w;
    if (mem_w) f3_ok = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    else       f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal = ~(mem_r & mem_w) & f3_ok & aligned;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata;
      end
    endcase
  end

  assign start      = (state == IDLE) & strobe & legal;
  assign stall      = srst_n & strobe & legal & (state != DONE);
  assign access_err = srst_n & (state == IDLE) & strobe & ~legal;

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    ld_done   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (bus_gnt) state_nxt = bus_we ? DONE : WAIT;
        else if (wd_cnt == WD_LAST) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      WAIT: begin
        // Completion wins over a watchdog expiring in the same cycle
        if (bus_rvalid) begin
          state_nxt = DONE;
          ld_done   = 1'b1;
        end else if (wd_cnt == WD_LAST) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = bus_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_ext = {24'd0, byte_sel};
      3'b101:  ld_ext = {16'd0, half_sel};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state     <= IDLE;
      wd_cnt    <= 8'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      read_data <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus_err <= abort;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_w;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_d;
        bus_wdata <= wdata_d;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        wd_cnt    <= 8'd0;
      end else if (state == REQ || state == WAIT) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
      if (state == REQ && state_nxt != REQ) bus_req <= 1'b0;
      if (ld_done)              read_data <= ld_ext;
      else if (abort && !bus_we) read_data <= 32'd0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, illegal accesses,
// watchdog abort and asynchronous reset during a pending read.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        srst_n;
  logic        mem_r, mem_w;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] read_data;
  logic        stall, access_err, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .srst_n(srst_n), .mem_r(mem_r), .mem_w(mem_w), .funct3(funct3),
    .addr(addr), .wdata(wdata), .read_data(read_data), .stall(stall),
    .access_err(access_err), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a clock edge with the DUT idle
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] exp_rd, input logic [3:0] exp_be);
    mem_r = 1'b1; funct3 = f3; addr = a;
    #1 check({tag, " stall c0"}, 32'(stall), 32'd1);
    tick();
    for (int i = 0; i < gnt_dly; i++) begin
      check({tag, " req held"}, 32'(bus_req), 32'd1);
      tick();
    end
    bus_gnt = 1'b1;
    #1;
    check({tag, " req"}, 32'(bus_req), 32'd1);
    check({tag, " addr"}, bus_addr, {a[31:2], 2'b00});
    check({tag, " be"}, 32'(bus_be), 32'(exp_be));
    check({tag, " we"}, 32'(bus_we), 32'd0);
    tick();
    bus_gnt = 1'b0;
    for (int i = 0; i < rv_dly; i++) tick();
    bus_rvalid = 1'b1; bus_rdata = rd;
    #1 check({tag, " stall wait"}, 32'(stall), 32'd1);
    tick();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #1;
    check({tag, " rdata"}, read_data, exp_rd);
    check({tag, " stall done"}, 32'(stall), 32'd0);
    tick();
    mem_r = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] keep_rd);
    mem_w = 1'b1; funct3 = f3; addr = a; wdata = wd;
    #1 check({tag, " stall c0"}, 32'(stall), 32'd1);
    tick();
    bus_gnt = 1'b1;
    #1;
    check({tag, " req"}, 32'(bus_req), 32'd1);
    check({tag, " we"}, 32'(bus_we), 32'd1);
    check({tag, " be"}, 32'(bus_be), 32'(exp_be));
    check({tag, " wdata"}, bus_wdata, exp_wd);
    check({tag, " addr"}, bus_addr, {a[31:2], 2'b00});
    tick();
    bus_gnt = 1'b0;
    #1;
    check({tag, " stall done"}, 32'(stall), 32'd0);
    check({tag, " req done"}, 32'(bus_req), 32'd0);
    check({tag, " rdata kept"}, read_data, keep_rd);
    tick();
    mem_w = 1'b0;
  endtask

  task automatic do_illegal(input string tag, input logic r, input logic w,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] keep_rd);
    mem_r = r; mem_w = w; funct3 = f3; addr = a;
    #1;
    check({tag, " err"}, 32'(access_err), 32'd1);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " bus_err"}, 32'(bus_err), 32'd0);
    tick();
    mem_r = 1'b0; mem_w = 1'b0;
    #1;
    check({tag, " err drop"}, 32'(access_err), 32'd0);
    check({tag, " no req"}, 32'(bus_req), 32'd0);
    check({tag, " rdata kept"}, read_data, keep_rd);
    tick();
  endtask

  initial begin
    srst_n = 1'b0; mem_r = 1'b0; mem_w = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    mem_r = 1'b1; funct3 = 3'b010;
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst rdata", read_data, 32'd0);
    check("rst req", 32'(bus_req), 32'd0);
    check("rst we", 32'(bus_we), 32'd0);
    check("rst addr", bus_addr, 32'd0);
    check("rst be", 32'(bus_be), 32'd0);
    check("rst wdata", bus_wdata, 32'd0);
    check("rst aerr", 32'(access_err), 32'd0);
    check("rst berr", 32'(bus_err), 32'd0);
    mem_r = 1'b0;
    srst_n = 1'b1;
    tick();

    do_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'b1111);
    do_load("lb", 3'b000, 32'h103, 32'h80112233, 1, 1, 32'hFFFFFF80, 4'b1000);
    do_load("lbu", 3'b100, 32'h103, 32'h80112233, 0, 0, 32'h00000080, 4'b1000);
    do_load("lh", 3'b001, 32'h102, 32'h9ABC1234, 0, 2, 32'hFFFF9ABC, 4'b1100);
    do_load("lhu", 3'b101, 32'h100, 32'h9ABC8234, 0, 0, 32'h00008234, 4'b0011);
    do_store("sh", 3'b001, 32'h202, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, 32'h00008234);
    do_store("sb", 3'b000, 32'h001, 32'h12345655, 4'b0010, 32'h55555555, 32'h00008234);
    do_illegal("mis lw", 1'b1, 1'b0, 3'b010, 32'h101, 32'h00008234);
    do_illegal("mis lh", 1'b1, 1'b0, 3'b001, 32'h103, 32'h00008234);
    do_illegal("both", 1'b1, 1'b1, 3'b010, 32'h100, 32'h00008234);
    do_illegal("bad sf3", 1'b0, 1'b1, 3'b100, 32'h100, 32'h00008234);

    // Asynchronous reset while a load waits for rvalid
    mem_r = 1'b1; funct3 = 3'b010; addr = 32'h400;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    #1 check("rstw stall pre", 32'(stall), 32'd1);
    #2 srst_n = 1'b0;
    #1;
    check("rstw stall", 32'(stall), 32'd0);
    check("rstw req", 32'(bus_req), 32'd0);
    check("rstw rdata", read_data, 32'd0);
    mem_r = 1'b0;
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    #2 srst_n = 1'b1;
    tick();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #1;
    check("rstw late rv", read_data, 32'd0);
    check("rstw idle req", 32'(bus_req), 32'd0);
    tick();
    do_load("lw after rst", 3'b010, 32'h404, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 4'b1111);

    // Watchdog: grant never arrives
    mem_r = 1'b1; funct3 = 3'b010; addr = 32'h300;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wd req", 32'(bus_req), 32'd1);
      check("wd stall", 32'(stall), 32'd1);
      check("wd berr low", 32'(bus_err), 32'd0);
      tick();
    end
    check("wd req drop", 32'(bus_req), 32'd0);
    check("wd berr", 32'(bus_err), 32'd1);
    check("wd aerr", 32'(access_err), 32'd0);
    check("wd stall done", 32'(stall), 32'd0);
    check("wd rdata", read_data, 32'd0);
    tick();
    mem_r = 1'b0;
    #1 check("wd berr pulse", 32'(bus_err), 32'd0);
    tick();

    do_load("lw final", 3'b010, 32'h500, 32'h01234567, 2, 0, 32'h01234567, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
